// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple counter through a 2-flop synchronizer and a settle filter,
// and emits valid/ready records of (value, delta, wrap). Optional wrap counter: RCS_WRAP_TOTAL_EN.
module ripple_count_sampler #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_count,
  output logic [WIDTH-1:0] out_delta,
  output logic             out_wrap,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       wrap_total
);

  localparam logic [3:0] STAB_MAX = 4'(SETTLE - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_cand;
  logic [3:0]       r_stab;
  logic [WIDTH-1:0] r_last;
  state_t           r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_delta;
  logic             r_wrap;
  logic [7:0]       r_drop;

  logic             w_accept;
  logic [WIDTH-1:0] w_delta;
  logic             w_wrap;

  // A value is accepted once it has been seen SETTLE times in a row and differs from the last one.
  assign w_accept = (r_stab == STAB_MAX) && (r_cand != r_last);
  assign w_delta  = r_cand - r_last;
  assign w_wrap   = (r_cand < r_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cand <= '0;
      r_stab <= '0;
      r_last <= '0;
    end else begin
      r_s1 <= count_in;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_stab <= '0;
      end else if (r_stab != STAB_MAX) begin
        r_stab <= r_stab + 4'd1;
      end
      if (w_accept) begin
        r_last <= r_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_count <= '0;
      r_delta <= '0;
      r_wrap  <= 1'b0;
      r_drop  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_count <= r_cand;
            r_delta <= w_delta;
            r_wrap  <= w_wrap;
            r_state <= HOLD;
            r_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (w_accept) begin
            if (out_ready) begin
              r_count <= r_cand;
              r_delta <= w_delta;
              r_wrap  <= w_wrap;
            end else if (r_drop != 8'hFF) begin
              r_drop <= r_drop + 8'd1;
            end
          end else if (out_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef RCS_WRAP_TOTAL_EN
  logic [7:0] r_wtot;

  // Counts every wrapping accept, including ones lost to backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wtot <= '0;
    end else if (w_accept && w_wrap && (r_wtot != 8'hFF)) begin
      r_wtot <= r_wtot + 8'd1;
    end
  end

  assign wrap_total = r_wtot;
`else
  assign wrap_total = '0;
`endif

  assign out_valid = r_valid;
  assign out_count = r_count;
  assign out_delta = r_delta;
  assign out_wrap  = r_wrap;
  assign drop_cnt  = r_drop;

endmodule

// File: doc/ripple_count_sampler.md
RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the sampled ripple-counter value.
REQ-002 The block SHALL have parameter SETTLE, default 2, range 1..15, giving the number of consecutive equal synchronized samples needed to accept a value.
REQ-003 The block SHALL have port clk, input, 1 bit: sampling clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port count_in, input, WIDTH bits: asynchronous ripple-counter output, bits may change in any order.
REQ-006 The block SHALL have port out_ready, input, 1 bit: consumer accepts the current record.
REQ-007 The block SHALL have port out_valid, output, 1 bit: record available.
REQ-008 The block SHALL have port out_count, output, WIDTH bits: accepted counter value.
REQ-009 The block SHALL have port out_delta, output, WIDTH bits: (out_count - previous accepted value) mod 2^WIDTH.
REQ-010 The block SHALL have port out_wrap, output, 1 bit: out_count < previous accepted value.
REQ-011 The block SHALL have port drop_cnt, output, 8 bits: saturating count of accepted values lost to backpressure.
REQ-012 The block SHALL have port wrap_total, output, 8 bits: running wrap count (see Configuration).

Function
REQ-013 Each count_in bit SHALL pass through a two-flop synchronizer (s1, s2).
REQ-014 Settle filter: if s2 != cand, cand <= s2 and stab <= 0; else stab increments, saturating at SETTLE-1.
REQ-015 Accept condition: stab == SETTLE-1 and cand != last. On accept, last <= cand in the same edge.
REQ-016 The FSM SHALL have states IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-017 On accept in IDLE: load out_count=cand, out_delta=cand-last, out_wrap=(cand<last), then go to HOLD.
REQ-018 HOLD with out_ready=1 and no accept: go to IDLE; out_valid deasserts on the next edge.
REQ-019 HOLD with out_ready=1 and an accept in the same cycle: load the new record and stay in HOLD (back-to-back, no bubble).
REQ-020 HOLD with out_ready=0 and an accept: keep the record unchanged, update last, and drop_cnt++ saturating at 255.
REQ-021 out_count, out_delta and out_wrap SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Latency: if count_in is stable from the edge-1 sample onward, out_valid SHALL rise at edge SETTLE+3 (edge 5 at default).
REQ-023 Changes shorter than SETTLE cycles after synchronization SHALL produce no record.
REQ-024 out_ready SHALL be ignored in IDLE.

Reset
REQ-025 reset low SHALL immediately clear s1, s2, cand, stab, last, the FSM (to IDLE), out_valid, out_count, out_delta, out_wrap, drop_cnt and wrap_total to 0.
REQ-026 Reset asserted mid-handshake SHALL discard the pending record; a count_in value of 0 after reset SHALL produce no record.
REQ-027 After reset release, the first accept SHALL compute delta against last=0.

Configuration
REQ-028 With macro RCS_WRAP_TOTAL_EN defined, wrap_total SHALL increment (saturating at 255) on every accept where cand < last, including accepts that are dropped.
REQ-029 Without RCS_WRAP_TOTAL_EN, wrap_total SHALL be constant 0 and no counter logic is instantiated.

Verification
REQ-030 Scenario: reset, then count_in=3 held, out_ready=1 -> out_valid high one cycle at edge 5, out_count=3, out_delta=3, out_wrap=0.
REQ-031 Scenario: last=14, count_in steps to 1 -> out_count=1, out_delta=3, out_wrap=1, wrap_total=1 (macro on) or 0 (macro off).
REQ-032 Scenario: count_in glitches 4->6->4 with 6 present one cycle, last=4 -> no out_valid, drop_cnt unchanged.
REQ-033 Scenario: out_ready=0, three accepted values 2, 5, 9 -> out_count stays 2, drop_cnt=2; then out_ready=1 -> next record delta is relative to 9.
REQ-034 Scenario: in HOLD, out_ready=1 coincides with the accept of 7 -> out_valid stays high, out_count=7 on the next edge.
REQ-035 Scenario: reset asserted while out_valid=1 -> out_valid=0 with no clock edge; all outputs 0.
